// File: rtl/mult_cdb_buffer.sv
// Completion buffer between the pipelined multiplier and the CDB arbiter.
// In-order FIFO of finished multiplies; back-pressures the multiplier via mult_avail.
module mult_cdb_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ROBN_W = 5,
    parameter int PRN_W  = 6,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              mult_done,
    input  logic [DATA_W-1:0] mult_result,
    input  logic [ROBN_W-1:0] mult_robn,
    input  logic [PRN_W-1:0]  mult_dest_prn,
    output logic              mult_avail,
    output logic              cdb_req,
    output logic [DATA_W-1:0] cdb_value,
    output logic [ROBN_W-1:0] cdb_robn,
    output logic [PRN_W-1:0]  cdb_dest_prn,
    input  logic              cdb_grant,
    output logic [CNT_W-1:0]  count,
    output logic [31:0]       stall_cycles
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] value_mem_q [DEPTH];
    logic [ROBN_W-1:0] robn_mem_q  [DEPTH];
    logic [PRN_W-1:0]  prn_mem_q   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      stall_q, stall_d;

    logic enq;
    logic deq;

    always_comb begin
        deq        = cdb_grant & cdb_req;
        mult_avail = flush | (count_q < FULL_CNT) | deq;
        enq        = mult_done & mult_avail & ~flush;
    end

    // Payload is forced to zero when empty so stale storage never leaks onto the CDB.
    always_comb begin
        cdb_req      = (count_q != '0);
        cdb_value    = '0;
        cdb_robn     = '0;
        cdb_dest_prn = '0;
        if (cdb_req) begin
            cdb_value    = value_mem_q[head_q];
            cdb_robn     = robn_mem_q[head_q];
            cdb_dest_prn = prn_mem_q[head_q];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        stall_d = stall_q;
        if (!mult_avail && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (deq) begin
                head_d = head_q + PTR_W'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CNT_W'(1);
            end else if (deq && !enq) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    // When full with a same-cycle grant, tail equals head, so the write lands in the freed slot.
    always_ff @(posedge clock) begin
        if (enq) begin
            value_mem_q[tail_q] <= mult_result;
            robn_mem_q[tail_q]  <= mult_robn;
            prn_mem_q[tail_q]   <= mult_dest_prn;
        end
    end

    assign count        = count_q;
    assign stall_cycles = stall_q;

endmodule

// File: doc/mult_cdb_buffer.md
Name: mult_cdb_buffer

Overview:
- Completion buffer directly downstream of the pipelined multiplier.
- Captures each finished multiply (result, ROB number, destination PRN) into a small in-order FIFO.
- Presents the oldest entry as a request to the CDB arbiter.
- Drives the multiplier's pipeline-advance signal (avail), so results are never lost or duplicated while the CDB is busy.

Parameters:
- DEPTH, 4, number of buffered completions; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- flush  in  1  synchronous discard of all buffered entries (mispredict recovery).
- mult_done  in  1  multiplier final stage holds a valid completion.
- mult_result  in  DATA  multiplier result.
- mult_robn  in  ROBN  ROB number of the completing op.
- mult_dest_prn  in  PRN  destination physical register.
- mult_avail  out  1  pipeline advance enable, fed to the multiplier's avail input.
- cdb_req  out  1  head entry valid, requesting the CDB.
- cdb_value  out  DATA  head result.
- cdb_robn  out  ROBN  head ROB number.
- cdb_dest_prn  out  PRN  head destination PRN.
- cdb_grant  in  1  arbiter grants the CDB to this unit this cycle.
- count  out  CNT_W  current occupancy.
- stall_cycles  out  32  saturating count of cycles with mult_avail=0.

Behaviour:
- Reset (reset=0, async):
  - head/tail pointers = 0, count = 0, stall_cycles = 0.
  - Entry storage is not reset.
  - Outputs during and after reset: cdb_req=0, mult_avail=1, cdb_* payload = 0 (payload forced to 0 whenever count=0).
- Dequeue:
  - deq = cdb_grant & cdb_req.
  - A grant while cdb_req=0 is ignored; the bench flags it as a protocol error.
- Advance enable:
  - mult_avail = flush | (count < DEPTH) | deq. Combinational.
  - A full buffer still lets the pipeline advance in the cycle its head is granted.
- Enqueue:
  - enq = mult_done & mult_avail & ~flush.
  - The multiplier's output registers are consumed exactly on the edge where the pipeline advances.
  - While mult_avail=0 the multiplier holds its outputs, and nothing is captured, so there is no duplicate capture.
- Latency:
  - Capture at edge N; cdb_req=1 with that payload from edge N onward (1-cycle registered latency).
  - No same-cycle bypass from mult_* to cdb_*.
- Ordering:
  - Strict FIFO; entries leave in capture order.
  - Pointers wrap modulo DEPTH.
- Count update per edge:
  - enq&~deq: +1. deq&~enq: -1. Both or neither: unchanged.
  - Simultaneous enq+deq when full: count stays DEPTH; the new entry is written into the slot freed by the head.
  - Simultaneous enq+deq when count=1: head advances and the new entry becomes head next cycle.
- Flush (sync, highest priority):
  - Next edge: count=0, head=tail=0.
  - The same-cycle enqueue is dropped.
  - A same-cycle grant is accepted by the arbiter but its entry is discarded anyway (the ROB is being squashed).
  - stall_cycles is not cleared.
- stall_cycles:
  - +1 each edge where mult_avail=0.
  - Saturates at 2^32-1.
- Invariants:
  - count <= DEPTH always.
  - cdb_req == (count != 0).
  - mult_avail=0 only when count==DEPTH & ~cdb_grant & ~flush.
- Reset mid-operation:
  - All buffered entries are lost; outputs immediately take their reset values (async).
  - Recovery is the ROB/rename reset's responsibility.

Test Plan:
- Single pass-through: reset released, mult_done=1 for one cycle with result=0x0000_0015, robn=3, prn=17, cdb_grant tied 1 -> next cycle cdb_req=1 with those values; following cycle cdb_req=0, count=0.
- Fill and stall (DEPTH=4): cdb_grant=0, five consecutive done cycles with robn 1..5 -> count reaches 4; mult_avail=0 while done holds robn 5; robn 5 not captured; stall_cycles increments each stalled cycle.
- Full with grant: from full, assert cdb_grant one cycle while robn 5 is presented -> robn 1 dequeued, robn 5 captured, count stays 4, mult_avail=1 that cycle; subsequent grants yield robn 2,3,4,5 in order.
- Wrap-around: stream 10 completions with grant every other cycle -> all 10 emerged in order with no drops or duplicates; pointers wrap at least twice.
- Flush: count=3 plus mult_done=1 and flush=1 in the same cycle -> next cycle count=0, cdb_req=0, the incoming entry is not captured, mult_avail=1 during the flush cycle.
- Async reset mid-stream: count=2, drop reset to 0 between clock edges -> cdb_req=0, count=0, mult_avail=1 immediately, without waiting for a clock edge.
